// File: rtl/conv3x3_engine_pkg.sv
// Shared constants and state encoding for the 3x3 convolution engine.
// The image side and the weight/output widths are fixed here for every file that imports the package.
package conv3x3_engine_pkg;
    localparam int IMG_N = 6;
    localparam int K     = 3;
    localparam int OUT_N = IMG_N - K + 1;
    localparam int NWIN  = OUT_N * OUT_N;
    localparam int NTAP  = K * K;
    localparam int NPIX  = IMG_N * IMG_N;
    localparam int WW    = 4;
    localparam int OW    = 8;
    localparam int RC_W  = $clog2(OUT_N);
    localparam int PIX_W = $clog2(NPIX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/conv3x3_engine_if.sv
// Frame control and result stream bundle between the engine (slave) and its driver/consumer (master).
// Stream handshake: a result transfers on a rising edge where out_valid & out_ready; while out_valid=1 and out_ready=0 every out_* field holds.
interface conv3x3_engine_if;
    import conv3x3_engine_pkg::*;

    logic                 start;
    logic [NPIX-1:0]      img;
    logic [NTAP*WW-1:0]   kernel;
    logic                 busy;
    logic                 done;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data;
    logic [RC_W-1:0]      out_row;
    logic [RC_W-1:0]      out_col;
    logic                 out_last;

    modport master (
        output start, img, kernel, out_ready,
        input  busy, done, out_valid, out_data, out_row, out_col, out_last
    );

    modport slave (
        input  start, img, kernel, out_ready,
        output busy, done, out_valid, out_data, out_row, out_col, out_last
    );
endinterface

// File: rtl/conv3x3_window_mac.sv
// Combinational 3x3 multiply-accumulate over binary pixels: each set pixel adds its signed weight.
// OW is wide enough for nine extreme weights, so the running sum never wraps.
module conv3x3_window_mac
    import conv3x3_engine_pkg::*;
(
    input  logic [NTAP-1:0]    i_pix,
    input  logic [NTAP*WW-1:0] i_w,
    output logic signed [OW-1:0] o_sum
);
    logic signed [OW-1:0] w_acc;
    logic [WW-1:0]        w_tap;

    always_comb begin
        w_acc = '0;
        w_tap = '0;
        for (int t = 0; t < NTAP; t++) begin
            w_tap = i_w[t*WW +: WW];
            if (i_pix[t]) begin
                w_acc = w_acc + {{(OW-WW){w_tap[WW-1]}}, w_tap};
            end
        end
        o_sum = w_acc;
    end
endmodule

// File: rtl/conv3x3_engine.sv
// Captures a binary image and signed 3x3 kernel on start, then streams the feature map in raster order.
// Results are registered; a new window is loaded whenever the output register is empty or being drained.
module conv3x3_engine
    import conv3x3_engine_pkg::*;
#(
    parameter bit RELU = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    conv3x3_engine_if.slave   io_bus,
    output state_t            o_dbg_state
);
    state_t               r_state;
    state_t               w_next_state;
    logic [NPIX-1:0]      r_img;
    logic [NTAP*WW-1:0]   r_kernel;
    logic [RC_W-1:0]      r_row;
    logic [RC_W-1:0]      r_col;
    logic                 r_out_valid;
    logic                 r_out_last;
    logic                 r_done;
    logic signed [OW-1:0] r_out_data;
    logic [RC_W-1:0]      r_out_row;
    logic [RC_W-1:0]      r_out_col;

    logic                 w_capture;
    logic                 w_load;
    logic                 w_drain_fire;
    logic                 w_busy;
    logic                 w_at_last;
    logic [PIX_W-1:0]     w_base;
    logic [NTAP-1:0]      w_pix;
    logic signed [OW-1:0] w_sum;
    logic signed [OW-1:0] w_result;

    assign w_at_last = (int'(r_row) * OUT_N + int'(r_col)) == (NWIN - 1);

    // Window (r,c) starts at pixel r*IMG_N+c of the captured image.
    always_comb begin
        w_base = PIX_W'(r_row) * PIX_W'(IMG_N) + PIX_W'(r_col);
        w_pix  = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                w_pix[i*K+j] = r_img[w_base + PIX_W'(i*IMG_N + j)];
            end
        end
    end

    conv3x3_window_mac u_mac (
        .i_pix (w_pix),
        .i_w   (r_kernel),
        .o_sum (w_sum)
    );

    assign w_result = (RELU && w_sum < 0) ? '0 : w_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (io_bus.start) w_next_state = S_RUN;
            S_RUN:   if (w_load && w_at_last) w_next_state = S_DRAIN;
            S_DRAIN: if (w_drain_fire) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_capture    = 1'b0;
        w_load       = 1'b0;
        w_drain_fire = 1'b0;
        w_busy       = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_busy    = 1'b0;
                w_capture = io_bus.start;
            end
            S_RUN:   w_load       = !r_out_valid || io_bus.out_ready;
            S_DRAIN: w_drain_fire = r_out_valid && io_bus.out_ready;
            default: w_busy       = 1'b0;
        endcase
    end

    // Image and kernel are only meaningful after a capture, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_img    <= io_bus.img;
            r_kernel <= io_bus.kernel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row       <= '0;
            r_col       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_drain_fire;
            if (w_capture) begin
                r_row <= '0;
                r_col <= '0;
            end
            if (w_load) begin
                r_out_data  <= w_result;
                r_out_row   <= r_row;
                r_out_col   <= r_col;
                r_out_last  <= w_at_last;
                r_out_valid <= 1'b1;
                if (r_col == RC_W'(OUT_N - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_drain_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign io_bus.busy      = w_busy;
    assign io_bus.done      = r_done;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_row   = r_out_row;
    assign io_bus.out_col   = r_out_col;
    assign io_bus.out_last  = r_out_last;
    assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_conv3x3_engine.sv
// Randomised bench for conv3x3_engine: a RELU=1 and a RELU=0 instance run in lockstep on the same stimulus.
// Expected results come from a direct window-sum model pushed into per-instance queues.
module tb_conv3x3_engine;
    import conv3x3_engine_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [35:0] img;
    logic [35:0] kernel;
    logic        out_ready;
    state_t      dbg1;
    state_t      dbg0;

    int n_cmp;
    int n_err;
    int hs_cnt;

    logic [12:0] exp_q1[$];
    logic [12:0] exp_q0[$];
    logic        stall1;
    logic        stall0;
    logic [12:0] held1;
    logic [12:0] held0;

    conv3x3_engine_if u_if1();
    conv3x3_engine_if u_if0();

    assign u_if1.start     = start;
    assign u_if1.img       = img;
    assign u_if1.kernel    = kernel;
    assign u_if1.out_ready = out_ready;
    assign u_if0.start     = start;
    assign u_if0.img       = img;
    assign u_if0.kernel    = kernel;
    assign u_if0.out_ready = out_ready;

    conv3x3_engine #(.RELU(1'b1)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .io_bus      (u_if1.slave),
        .o_dbg_state (dbg1)
    );

    conv3x3_engine #(.RELU(1'b0)) u_dut0 (
        .clk         (clk),
        .rst         (rst),
        .io_bus      (u_if0.slave),
        .o_dbg_state (dbg0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: window sum straight from the pixel/weight definitions.
    function automatic logic [7:0] model(input logic [35:0] im, input logic [35:0] kr,
                                         input int r, input int c, input bit relu);
        int s;
        int w;
        logic [3:0] wb;
        s = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                wb = kr[(i*3+j)*4 +: 4];
                w  = int'(wb);
                if (w > 7) w = w - 16;
                if (im[(r+i)*6 + (c+j)]) s = s + w;
            end
        end
        if (relu && s < 0) s = 0;
        return 8'(s);
    endfunction

    task automatic push_frame(input logic [35:0] im, input logic [35:0] kr);
        logic [1:0] rr;
        logic [1:0] cc;
        logic       last;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                rr   = 2'(r);
                cc   = 2'(c);
                last = (r == 3 && c == 3);
                exp_q1.push_back({rr, cc, last, model(im, kr, r, c, 1'b1)});
                exp_q0.push_back({rr, cc, last, model(im, kr, r, c, 1'b0)});
            end
        end
    endtask

    task automatic sample_outputs();
        logic [12:0] pk1;
        logic [12:0] pk0;
        pk1 = {u_if1.out_row, u_if1.out_col, u_if1.out_last, u_if1.out_data};
        pk0 = {u_if0.out_row, u_if0.out_col, u_if0.out_last, u_if0.out_data};
        if (stall1) check("hold_relu1", 32'({u_if1.out_valid, pk1}), 32'({1'b1, held1}));
        if (stall0) check("hold_relu0", 32'({u_if0.out_valid, pk0}), 32'({1'b1, held0}));
        if (u_if1.out_valid && out_ready) begin
            if (exp_q1.size() == 0) check("extra_relu1", 32'(1), 32'(0));
            else check("res_relu1", 32'(pk1), 32'(exp_q1.pop_front()));
            hs_cnt++;
        end
        if (u_if0.out_valid && out_ready) begin
            if (exp_q0.size() == 0) check("extra_relu0", 32'(1), 32'(0));
            else check("res_relu0", 32'(pk0), 32'(exp_q0.pop_front()));
        end
        stall1 = u_if1.out_valid && !out_ready;
        stall0 = u_if0.out_valid && !out_ready;
        held1  = pk1;
        held0  = pk0;
    endtask

    function automatic logic [31:0] all_outs1();
        return 32'({u_if1.out_valid, u_if1.busy, u_if1.done, u_if1.out_last,
                    u_if1.out_row, u_if1.out_col, u_if1.out_data});
    endfunction

    function automatic logic [31:0] all_outs0();
        return 32'({u_if0.out_valid, u_if0.busy, u_if0.done, u_if0.out_last,
                    u_if0.out_row, u_if0.out_col, u_if0.out_data});
    endfunction

    // rmode: 0 ready high, 1 ready 1,0,0 repeating, 2 random ready.
    // abort_at >= 0 resets after that many accepted results; chain holds start high across done.
    task automatic run_frame(input logic [35:0] im, input logic [35:0] kr, input int rmode,
                             input int abort_at, input bit chain);
        int  k;
        int  dones;
        int  nframes;
        bit  aborted;
        bit  poked;
        bit  seen_done;
        nframes = chain ? 2 : 1;
        for (int f = 0; f < nframes; f++) push_frame(im, kr);
        hs_cnt  = 0;
        k       = 0;
        dones   = 0;
        aborted = 1'b0;
        poked   = 1'b0;
        @(posedge clk); #1;
        img       = im;
        kernel    = kr;
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        sample_outputs();
        check("busy_before_start", 32'(u_if1.busy), 32'(0));
        while (dones < nframes && !aborted && k < 400) begin
            @(posedge clk); #1;
            k++;
            if (!chain || dones > 0) start = 1'b0;
            if (!chain) begin
                img    = 36'({$urandom(), $urandom()});
                kernel = 36'({$urandom(), $urandom()});
                if (hs_cnt == 5 && !poked) begin
                    start = 1'b1;
                    poked = 1'b1;
                end
            end
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (abort_at >= 0 && hs_cnt == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check("abort_zero_relu1", all_outs1(), 32'(0));
                check("abort_zero_relu0", all_outs0(), 32'(0));
                seen_done = 1'b0;
                repeat (25) begin
                    @(negedge clk);
                    seen_done = seen_done | u_if1.done | u_if0.done;
                end
                check("abort_no_done", 32'(seen_done), 32'(0));
                exp_q1.delete();
                exp_q0.delete();
                stall1  = 1'b0;
                stall0  = 1'b0;
                aborted = 1'b1;
            end else begin
                @(negedge clk);
                sample_outputs();
                check("done_pair", 32'(u_if0.done), 32'(u_if1.done));
                if (rmode == 0 && k == 1) begin
                    check("busy_after_start", 32'(u_if1.busy), 32'(1));
                    check("valid_at_t1", 32'(u_if1.out_valid), 32'(0));
                end
                if (rmode == 0 && k == 2) check("valid_at_t2", 32'(u_if1.out_valid), 32'(1));
                if (u_if1.done) begin
                    dones++;
                    check("busy_at_done", 32'(u_if1.busy), 32'(0));
                    if (rmode == 0) check("done_cycle", 32'(k), 32'(18 * dones));
                end
            end
        end
        if (!aborted) begin
            if (dones < nframes) check("frame_timeout", 32'(dones), 32'(nframes));
            check("handshakes", 32'(hs_cnt), 32'(16 * nframes));
            check("queue_empty", 32'(exp_q1.size() + exp_q0.size()), 32'(0));
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            sample_outputs();
            check("done_one_cycle", 32'(u_if1.done), 32'(0));
        end
    endtask

    initial begin
        logic [35:0] k3;
        n_cmp     = 0;
        n_err     = 0;
        hs_cnt    = 0;
        stall1    = 1'b0;
        stall0    = 1'b0;
        held1     = '0;
        held0     = '0;
        rst       = 1'b1;
        start     = 1'b0;
        img       = '0;
        kernel    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs_relu1", all_outs1(), 32'(0));
        check("reset_outs_relu0", all_outs0(), 32'(0));
        check("reset_state", 32'(dbg1), 32'(S_IDLE));
        @(posedge clk); #1;
        rst = 1'b0;

        run_frame('1, 36'h111111111, 0, -1, 1'b0);
        run_frame('1, 36'h888888888, 0, -1, 1'b0);
        for (int n = 0; n < 9; n++) k3[n*4 +: 4] = 4'(n - 4);
        run_frame(36'(1) << 14, k3, 0, -1, 1'b0);
        run_frame(36'({$urandom(), $urandom()}), 36'({$urandom(), $urandom()}), 1, -1, 1'b0);
        run_frame(36'({$urandom(), $urandom()}), 36'({$urandom(), $urandom()}), 0, 8, 1'b0);
        run_frame(36'({$urandom(), $urandom()}), 36'({$urandom(), $urandom()}), 0, -1, 1'b0);
        run_frame(36'({$urandom(), $urandom()}), 36'({$urandom(), $urandom()}), 0, -1, 1'b1);
        for (int f = 0; f < 4; f++) begin
            run_frame(36'({$urandom(), $urandom()}), 36'({$urandom(), $urandom()}), 2, -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
